// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment display scanner: synchronizes segment/digit lines, waits
// for a stable sample run, decodes each digit to a hex nibble and assembles frames.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic                    frame_valid,
  output logic                    err,
  output logic [6:0]              err_pattern
);

  localparam int         SW       = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [7:0] PRE_C    = 8'(STABLE_CYCLES - 1);

  // Returns {legal, nibble}; legal = 0 for any pattern outside the hex table.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]              seg_s1_r, seg_s2_r;
  logic [NUM_DIGITS-1:0]   sel_s1_r, sel_s2_r;
  logic [SW-1:0]           prev_r;
  logic [7:0]              cnt_r;
  logic [NUM_DIGITS-1:0]   seen_r;

  logic [SW-1:0]           cur_s;
  logic                    onehot_s;
  logic                    capture_s;
  logic [4:0]              dec_s;
  logic [4*NUM_DIGITS-1:0] value_nx_s;
  logic [NUM_DIGITS-1:0]   dv_nx_s;
  logic [NUM_DIGITS-1:0]   seen_nx_s;
  logic                    err_nx_s;
  logic [6:0]              errpat_nx_s;
  logic                    frame_nx_s;

  assign cur_s     = {sel_s2_r, seg_s2_r};
  assign onehot_s  = ($countones(sel_s2_r) == 32'd1);
  // Capture fires only on the single edge where the stability counter reaches its ceiling.
  assign capture_s = (cur_s == prev_r) && (cnt_r == PRE_C) && onehot_s;
  assign dec_s     = decode_seg(seg_s2_r);

  // Two-flop synchronizers, previous-sample register and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_r <= 7'd0;
      seg_s2_r <= 7'd0;
      sel_s1_r <= '0;
      sel_s2_r <= '0;
      prev_r   <= '0;
      cnt_r    <= 8'd0;
    end else begin
      seg_s1_r <= seg_in;
      seg_s2_r <= seg_s1_r;
      sel_s1_r <= dig_sel;
      sel_s2_r <= sel_s1_r;
      prev_r   <= cur_s;
      if (cur_s != prev_r) begin
        cnt_r <= 8'd0;
      end else if (cnt_r != STABLE_C) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state decode of a capture into the digit, error and frame bookkeeping.
  always_comb begin
    value_nx_s  = value;
    dv_nx_s     = digit_valid;
    seen_nx_s   = seen_r;
    err_nx_s    = 1'b0;
    errpat_nx_s = err_pattern;
    frame_nx_s  = 1'b0;
    if (capture_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_s2_r[i]) begin
          if (dec_s[4]) begin
            value_nx_s[4*i +: 4] = dec_s[3:0];
            dv_nx_s[i]           = 1'b1;
          end else if (seg_s2_r == 7'd0) begin
            value_nx_s[4*i +: 4] = 4'd0;
            dv_nx_s[i]           = 1'b0;
          end else begin
            err_nx_s    = 1'b1;
            errpat_nx_s = seg_s2_r;
            dv_nx_s[i]  = 1'b0;
          end
          seen_nx_s[i] = 1'b1;
        end else begin
          seen_nx_s[i] = seen_nx_s[i];
        end
      end
      // A frame closes on the capture that fills the seen mask.
      if (seen_nx_s == {NUM_DIGITS{1'b1}}) begin
        frame_nx_s = 1'b1;
        seen_nx_s  = '0;
      end else begin
        frame_nx_s = 1'b0;
      end
    end else begin
      frame_nx_s = 1'b0;
    end
  end

  // Registered outputs and seen mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      frame_value <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_pattern <= 7'd0;
      seen_r      <= '0;
    end else begin
      value       <= value_nx_s;
      digit_valid <= dv_nx_s;
      seen_r      <= seen_nx_s;
      err         <= err_nx_s;
      err_pattern <= errpat_nx_s;
      frame_valid <= frame_nx_s;
      if (frame_nx_s) begin
        frame_value <= value_nx_s;
      end else begin
        frame_value <= frame_value;
      end
    end
  end

endmodule
